// File: rtl/bypass_back_pkg.sv
// bypass_back_pkg: shared state/source encodings and default widths for the bypass back merge
package bypass_back_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER_NF  = 2'd1,
        XFER_BYP = 2'd2
    } state_t;

    typedef enum logic {
        SRC_NF  = 1'b0,
        SRC_BYP = 1'b1
    } src_t;

    localparam int DATA_W_DEF  = 512;
    localparam int EMPTY_W_DEF = 6;
    localparam int META_W_DEF  = 128;
endpackage

// File: rtl/bypass_back_oreg.sv
// bypass_back_oreg: single-entry valid/ready register slice; accepts when empty or being drained
module bypass_back_oreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            out_valid <= 1'b0;
        else if (in_ready)
            out_valid <= in_valid;

    always_ff @(posedge clk)
        if (in_valid && in_ready)
            out_data <= in_data;
endmodule

// File: rtl/bypass_back_merge.sv
// bypass_back_merge: packet-granular round-robin merge of NF and bypass pkt/meta streams onto one egress pair
// Optional BYPASS_BACK_MERGE_STATS_EN adds nf_pkt_cnt/byp_pkt_cnt eop counters.
module bypass_back_merge
    import bypass_back_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int EMPTY_W = EMPTY_W_DEF,
    parameter int META_W  = META_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  nf_pkt_data,
    input  logic               nf_pkt_sop,
    input  logic               nf_pkt_eop,
    input  logic [EMPTY_W-1:0] nf_pkt_empty,
    input  logic               nf_pkt_valid,
    output logic               nf_pkt_ready,
    input  logic [META_W-1:0]  nf_meta_data,
    input  logic               nf_meta_valid,
    output logic               nf_meta_ready,
    input  logic [DATA_W-1:0]  byp_pkt_data,
    input  logic               byp_pkt_sop,
    input  logic               byp_pkt_eop,
    input  logic [EMPTY_W-1:0] byp_pkt_empty,
    input  logic               byp_pkt_valid,
    output logic               byp_pkt_ready,
    input  logic [META_W-1:0]  byp_meta_data,
    input  logic               byp_meta_valid,
    output logic               byp_meta_ready,
    output logic [DATA_W-1:0]  out_pkt_data,
    output logic               out_pkt_sop,
    output logic               out_pkt_eop,
    output logic [EMPTY_W-1:0] out_pkt_empty,
    output logic               out_pkt_valid,
    input  logic               out_pkt_ready,
    output logic [META_W-1:0]  out_meta_data,
    output logic               out_meta_valid,
    input  logic               out_meta_ready,
    output logic               orphan_err
`ifdef BYPASS_BACK_MERGE_STATS_EN
    ,
    output logic [31:0]        nf_pkt_cnt,
    output logic [31:0]        byp_pkt_cnt
`endif
);
    localparam int PW = DATA_W + EMPTY_W + 2;

    state_t            state;
    src_t              rr_last, gnt;
    logic              active, idle, nf_xfer, byp_xfer, nf_elig, byp_elig, gnt_v;
    logic              nf_done, byp_done, orphan, p_acc, m_acc, p_in_v;
    logic [PW-1:0]     p_in, p_out;
    logic [META_W-1:0] m_in;

    // active holds every ready low from reset assertion until the first edge after release
    always_comb begin
        idle           = active && state == IDLE;
        nf_xfer        = active && state == XFER_NF;
        byp_xfer       = active && state == XFER_BYP;
        nf_elig        = nf_meta_valid && nf_pkt_valid && nf_pkt_sop;
        byp_elig       = byp_meta_valid && byp_pkt_valid && byp_pkt_sop;
        gnt_v          = idle && (nf_elig || byp_elig);
        gnt            = (nf_elig && byp_elig) ? ((rr_last == SRC_NF) ? SRC_BYP : SRC_NF) : (nf_elig ? SRC_NF : SRC_BYP);
        nf_meta_ready  = gnt_v && gnt == SRC_NF && m_acc;
        byp_meta_ready = gnt_v && gnt == SRC_BYP && m_acc;
        m_in           = (gnt == SRC_NF) ? nf_meta_data : byp_meta_data;
        nf_pkt_ready   = nf_xfer ? p_acc : idle && nf_pkt_valid && !nf_pkt_sop;
        byp_pkt_ready  = byp_xfer ? p_acc : idle && byp_pkt_valid && !byp_pkt_sop;
        orphan         = idle && ((nf_pkt_valid && !nf_pkt_sop) || (byp_pkt_valid && !byp_pkt_sop));
        p_in           = byp_xfer ? {byp_pkt_data, byp_pkt_sop, byp_pkt_eop, byp_pkt_empty}
                                  : {nf_pkt_data, nf_pkt_sop, nf_pkt_eop, nf_pkt_empty};
        p_in_v         = (nf_xfer && nf_pkt_valid) || (byp_xfer && byp_pkt_valid);
        nf_done        = nf_xfer && nf_pkt_valid && p_acc && nf_pkt_eop;
        byp_done       = byp_xfer && byp_pkt_valid && p_acc && byp_pkt_eop;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            active     <= 1'b0;
            state      <= IDLE;
            rr_last    <= SRC_BYP;
            orphan_err <= 1'b0;
        end else begin
            active <= 1'b1;
            if (orphan)
                orphan_err <= 1'b1;
            if (gnt_v && m_acc)
                state <= (gnt == SRC_NF) ? XFER_NF : XFER_BYP;
            else if (nf_done) begin
                state   <= IDLE;
                rr_last <= SRC_NF;
            end else if (byp_done) begin
                state   <= IDLE;
                rr_last <= SRC_BYP;
            end
        end

`ifdef BYPASS_BACK_MERGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            nf_pkt_cnt  <= '0;
            byp_pkt_cnt <= '0;
        end else begin
            nf_pkt_cnt  <= nf_pkt_cnt + 32'(nf_done);
            byp_pkt_cnt <= byp_pkt_cnt + 32'(byp_done);
        end
`endif

    bypass_back_oreg #(.W(PW)) u_pkt_oreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (p_in),
        .in_valid  (p_in_v),
        .in_ready  (p_acc),
        .out_data  (p_out),
        .out_valid (out_pkt_valid),
        .out_ready (out_pkt_ready)
    );

    bypass_back_oreg #(.W(META_W)) u_meta_oreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (m_in),
        .in_valid  (gnt_v),
        .in_ready  (m_acc),
        .out_data  (out_meta_data),
        .out_valid (out_meta_valid),
        .out_ready (out_meta_ready)
    );

    assign {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty} = p_out;
endmodule

// File: doc/bypass_back_merge.md
Name: bypass_back_merge

Overview:
- Return-side counterpart of the bypass front splitter. It merges the NF-processed stream (pkt + meta) and the bypass stream (pkt + meta) back into a single Avalon-ST pkt/meta pair for the egress path.
- Arbitration is round-robin at packet granularity. A packet is never interleaved with another.
- Meta is forwarded once per packet, before or alongside that packet's SOP beat.

Parameters:
- DATA_W, 512: pkt data width.
- EMPTY_W, 6: pkt empty width, log2(DATA_W/8).
- META_W, 128: meta word width.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- nf_pkt_data/sop/eop/empty/valid  in  DATA_W/1/1/EMPTY_W/1  NF-path packet beat
- nf_pkt_ready  out  1  NF-path packet accept
- nf_meta_data/valid  in  META_W/1  NF-path meta
- nf_meta_ready  out  1  NF-path meta accept
- byp_pkt_data/sop/eop/empty/valid  in  DATA_W/1/1/EMPTY_W/1  bypass packet beat
- byp_pkt_ready  out  1  bypass packet accept
- byp_meta_data/valid  in  META_W/1  bypass meta
- byp_meta_ready  out  1  bypass meta accept
- out_pkt_data/sop/eop/empty/valid  out  DATA_W/1/1/EMPTY_W/1  merged packet
- out_pkt_ready  in  1  egress packet accept
- out_meta_data/valid  out  META_W/1  merged meta
- out_meta_ready  in  1  egress meta accept
- orphan_err  out  1  sticky flag: non-SOP beat seen while idle

Behaviour:
- Reset (Rst_n low, async):
  - all out_*_valid = 0, all *_ready = 0, orphan_err = 0.
  - state = IDLE, rr_last = BYP, so the NF path wins the first tie.
- Transfers occur when valid and ready are both high on a rising Clk edge.
- Output stage: one register stage each for pkt and meta (oreg). Each can accept when it is empty or is being drained this cycle (out_ready high). Input-to-output latency is 1 cycle. Full throughput: 1 beat/cycle sustained while out_pkt_ready stays high.
- States: IDLE, XFER_NF, XFER_BYP.
- IDLE:
  - A source is eligible when meta_valid, pkt_valid and pkt_sop are all high.
  - If both sources are eligible, grant the one not equal to rr_last. If one is eligible, grant it.
  - On grant, the granted meta_ready is asserted only if the meta oreg can accept. On meta transfer, go to XFER_<src>. No pkt beat is taken in the grant cycle.
  - A source whose pkt_valid is high with sop = 0 and no grant in progress: the beat is consumed and dropped (pkt_ready = 1 for that cycle) and orphan_err is set. orphan_err stays set until reset.
- XFER_src:
  - src_pkt_ready = pkt oreg can accept. The other source's readies stay 0. Beats are copied unchanged.
  - On transfer of the beat with eop = 1: rr_last <- src, next state IDLE. The next grant is evaluated the following cycle, giving one bubble cycle between packets.
  - sop = 1 seen mid-packet: forwarded unchanged, not checked.
  - A beat with sop = 1 and eop = 1 (single-beat packet): eop rule applies, return to IDLE.
- Meta and pkt oregs drain independently. The meta for packet N+1 cannot be accepted until packet N's eop has transferred in.
- Reset mid-packet: truncates the output. There is no recovery framing.

Optional Feature:
- Macro: BYPASS_BACK_MERGE_STATS_EN.
- When defined, adds outputs nf_pkt_cnt[31:0] and byp_pkt_cnt[31:0].
  - Each counter increments on an eop transfer from the corresponding input.
  - Reset to 0; wrap modulo 2^32.
  - Dropped orphan beats are not counted.
- When undefined: no ports, no counter logic.

Decomposition:
- Shared package bypass_back_pkg: state enum (IDLE, XFER_NF, XFER_BYP), source enum (SRC_NF, SRC_BYP), default width constants.
- Sub-module bypass_back_oreg: a parameterised single-entry register with valid/ready, holding data and flags. Instantiated once for pkt (data, sop, eop, empty) and once for meta.

Test Plan:
- NF only, 3-beat packet, meta 0xA5, out ready held high -> out_meta = 0xA5 one cycle after grant; 3 pkt beats out with sop on beat 1 and eop on beat 3; 1-cycle latency per beat.
- Both sources eligible from reset -> NF packet first, then bypass; next NF + bypass pair -> NF, bypass again (alternation holds); one bubble cycle between packets.
- Bypass 4-beat packet with out_pkt_ready toggling 1,0,1,0 -> no beat lost or duplicated; byp_pkt_ready mirrors oreg space; NF stays blocked until the eop transfers.
- NF pkt_valid with sop = 0 in IDLE -> beat dropped, orphan_err = 1 and held; the next proper NF packet merges normally.
- Rst_n pulsed low mid-packet -> all valids and readies 0 immediately; after release the first eligible packet is granted normally; with stats enabled, counters = 0.
- With BYPASS_BACK_MERGE_STATS_EN: 5 NF and 3 bypass packets -> nf_pkt_cnt = 5, byp_pkt_cnt = 3.
